demux_1by4_stream: RTL and testbench

//  Registered 1-to-4 stream demultiplexer; the inverse of the team's 4:1 data mux.

---
 rtl/demux_1by4_stream_if.sv | 30 +++
 rtl/demux_1by4_stream.sv | 100 ++++++++++
 tb/tb_demux_1by4_stream.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/demux_1by4_stream_if.sv
// Stream bundle for the 1-to-4 demux.
//  master : upstream producer + downstream consumers (drives word, select, out_ready)
//  slave  : the demux itself (drives in_ready, channel valids/data, counters)
//  in_valid/in_ready/in_data/s : single input stream, s picks the channel
//  out_valid/out_ready         : one handshake bit per channel
//  out_data                    : channel k word at [k*W +: W]
//  cnt                         : channel k accepted-word count at [k*CW +: CW]
interface demux_1by4_stream_if #(
    parameter int W  = 8,
    parameter int CW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic [1:0]      s;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [4*W-1:0]  out_data;
    logic [4*CW-1:0] cnt;

    modport master (
        output in_valid, in_data, s, out_ready,
        input  in_ready, out_valid, out_data, cnt
    );

    modport slave (
        input  in_valid, in_data, s, out_ready,
        output in_ready, out_valid, out_data, cnt
    );
endinterface

// File: rtl/demux_1by4_stream.sv
// Registered 1-to-4 stream demultiplexer.
// One word per cycle enters on a valid/ready input and is written into the
// one-entry output register of the channel chosen by {s[0],s[1]}. Each
// channel has its own valid/ready handshake and a wrapping accept counter.
//  clk : rising-edge clock
//  rst : synchronous active-high reset (clears valids, data and counters)
//  bus : demux_1by4_stream_if.slave stream bundle

// One output channel: a single-entry register plus its accept counter.
//  load_i  : a word for this channel is accepted this cycle
//  ready_i : channel consumer takes the held word this cycle
//  data_i  : incoming word
//  valid_o / data_o / cnt_o : register contents and accept count
module demux_1by4_stream_ch #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          ready_i,
    input  logic [W-1:0]  data_i,
    output logic          valid_o,
    output logic [W-1:0]  data_o,
    output logic [CW-1:0] cnt_o
);
    logic          vld_q, vld_d;
    logic [W-1:0]  dat_q, dat_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        cnt_d = cnt_q;
        if (vld_q && ready_i) begin
            vld_d = 1'b0;
        end
        // A load on the same edge as a drain wins, so the channel never bubbles.
        if (load_i) begin
            vld_d = 1'b1;
            dat_d = data_i;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= 1'b0;
            dat_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid_o = vld_q;
    assign data_o  = dat_q;
    assign cnt_o   = cnt_q;
endmodule

module demux_1by4_stream #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    demux_1by4_stream_if.slave   bus
);
    logic [1:0]          sel;
    logic                accept;
    logic [3:0]          vld;
    logic [3:0][W-1:0]   dat;
    logic [3:0][CW-1:0]  cnt;

    // s[0] is the MSB of the channel index.
    assign sel = {bus.s[0], bus.s[1]};

    // Ready depends only on the selected channel's state, never on in_valid.
    assign bus.in_ready = ~rst & (~vld[sel] | bus.out_ready[sel]);
    assign accept       = bus.in_valid & bus.in_ready;

    for (genvar k = 0; k < 4; k++) begin : g_ch
        demux_1by4_stream_ch #(.W(W), .CW(CW)) u_ch (
            .clk_i   (clk),
            .rst_i   (rst),
            .load_i  (accept && (sel == 2'(k))),
            .ready_i (bus.out_ready[k]),
            .data_i  (bus.in_data),
            .valid_o (vld[k]),
            .data_o  (dat[k]),
            .cnt_o   (cnt[k])
        );
    end

    assign bus.out_valid = vld;
    assign bus.out_data  = dat;
    assign bus.cnt       = cnt;
endmodule

// File: tb/tb_demux_1by4_stream.sv
// Bench for demux_1by4_stream: directed scenarios followed by random traffic,
// all checked every cycle against a channel-level reference model.
module tb_demux_1by4_stream;
    localparam int W  = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_1by4_stream_if #(.W(W), .CW(CW)) bus ();

    demux_1by4_stream #(.W(W), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: what each channel holds and how many words it took.
    bit          mvld [4];
    logic [7:0]  mdat [4];
    int          mcnt [4];
    bit          live;
    bit          last_block;
    int          n_chk, n_pass;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int chan(input logic [1:0] sv);
        return int'(sv[0]) * 2 + int'(sv[1]);
    endfunction

    task automatic cyc(input bit r, input bit iv, input logic [7:0] d,
                       input logic [1:0] sv, input logic [3:0] ordy);
        int k;
        bit exp_rdy;
        rst           = r;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.s         = sv;
        bus.out_ready = ordy;
        @(negedge clk);
        k       = chan(sv);
        exp_rdy = !r && (!mvld[k] || ordy[k]);
        chk("in_ready", bus.in_ready, exp_rdy);
        if (live) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("out_valid%0d", j), bus.out_valid[j], mvld[j]);
                chk($sformatf("out_data%0d", j), bus.out_data[j*8 +: 8], mdat[j]);
                chk($sformatf("cnt%0d", j), bus.cnt[j*8 +: 8], mcnt[j]);
            end
        end
        @(posedge clk);
        if (r) begin
            for (int j = 0; j < 4; j++) begin
                mvld[j] = 0; mdat[j] = 8'h00; mcnt[j] = 0;
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (mvld[j] && ordy[j]) mvld[j] = 0;
            end
            if (iv && exp_rdy) begin
                mvld[k] = 1;
                mdat[k] = d;
                mcnt[k] = (mcnt[k] + 1) % 256;
            end
        end
        live       = 1;
        last_block = iv && !exp_rdy;
        #1;
    endtask

    initial begin : main
        logic [1:0] svals [4];
        logic [7:0] rd;
        logic [1:0] rs;
        bit         riv;
        svals[0] = 2'b00; svals[1] = 2'b10; svals[2] = 2'b01; svals[3] = 2'b11;
        for (int j = 0; j < 4; j++) begin
            mvld[j] = 0; mdat[j] = 8'h00; mcnt[j] = 0;
        end
        live = 0; last_block = 0; n_chk = 0; n_pass = 0;

        // Reset with in_valid high: nothing may be accepted.
        cyc(1, 1, 8'hFF, 2'b00, 4'hF);
        cyc(1, 1, 8'hEE, 2'b11, 4'hF);
        chk("rst_valid", bus.out_valid, 4'h0);
        chk("rst_data", bus.out_data, 32'h0);
        chk("rst_cnt", bus.cnt, 32'h0);

        // Routing: one word to each channel, visible one edge later.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 8'hA0 + 8'(i), svals[i], 4'hF);
            chk($sformatf("route_data%0d", i), bus.out_data[i*8 +: 8], 8'hA0 + 8'(i));
            chk($sformatf("route_vld%0d", i), bus.out_valid[i], 1'b1);
        end
        cyc(0, 0, 8'h00, 2'b00, 4'hF);
        chk("route_cnt", bus.cnt, 32'h01010101);

        // Backpressure on ch2, with ch3 still flowing.
        cyc(0, 1, 8'h55, 2'b01, 4'b1011);
        chk("bp_load55", bus.out_data[23:16], 8'h55);
        cyc(0, 1, 8'h77, 2'b11, 4'b1011);
        chk("iso_ch3", bus.out_data[31:24], 8'h77);
        chk("iso_ch2", bus.out_data[23:16], 8'h55);
        chk("iso_vld", bus.out_valid[3:2], 2'b11);
        cyc(0, 1, 8'h66, 2'b01, 4'b1011);
        chk("bp_hold", bus.out_data[23:16], 8'h55);
        cyc(0, 1, 8'h66, 2'b01, 4'b1111);
        chk("bp_replace", bus.out_data[23:16], 8'h66);
        chk("bp_nobubble", bus.out_valid[2], 1'b1);
        chk("bp_cnt2", bus.cnt[23:16], 8'd3);

        // Mid-operation reset with stalled channels.
        cyc(0, 1, 8'h11, 2'b00, 4'h0);
        cyc(0, 1, 8'h33, 2'b11, 4'h0);
        chk("mid_pre_vld", {bus.out_valid[3], bus.out_valid[0]}, 2'b11);
        cyc(1, 0, 8'h00, 2'b00, 4'h0);
        chk("mid_vld", bus.out_valid, 4'h0);
        chk("mid_cnt", bus.cnt, 32'h0);
        cyc(0, 1, 8'h99, 2'b00, 4'h0);
        chk("mid_next", bus.out_data[7:0], 8'h99);
        chk("mid_next_cnt", bus.cnt[7:0], 8'd1);

        // Counter wrap on ch1.
        for (int i = 0; i < 256; i++) cyc(0, 1, 8'($urandom), 2'b10, 4'hF);
        chk("wrap_cnt1", bus.cnt[15:8], 8'd0);
        chk("wrap_cnt0", bus.cnt[7:0], 8'd1);
        chk("wrap_cnt23", bus.cnt[31:16], 16'd0);

        // Random traffic, honouring the hold-while-stalled rule upstream.
        rd = 8'h00; rs = 2'b00; riv = 0;
        for (int i = 0; i < 600; i++) begin
            if (!last_block) begin
                riv = ($urandom_range(3) != 0);
                rd  = 8'($urandom);
                rs  = 2'($urandom);
            end
            cyc(($urandom_range(63) == 0), riv, rd, rs, 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
